// File: rtl/chunked_add_serial.sv
// rtl/chunked_add_serial.sv - multi-cycle adder, one CHUNK_WIDTH slice per clock, valid/ready on both sides
// Optional feature macro: CHUNKED_ADD_SERIAL_SUB_EN adds the op_sub port (a-b via a + ~b + 1).
module chunked_add_serial #(
  parameter int WIDTH       = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CHUNKED_ADD_SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   carry_q;
  logic                   last_chunk;
  logic                   sub_sel;
  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   chunk_sum;

`ifdef CHUNKED_ADD_SERIAL_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last_chunk = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Mux the active slice out of each operand; the carry chain is only CHUNK_WIDTH+1 long.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
  end

  // b is stored already inverted for subtraction, so BUSY is a plain add with carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= sub_sel ? ~b : b;
      carry_q <= sub_sel;
      idx_q   <= '0;
    end else if (state_q == BUSY) begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          out[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum[CHUNK_WIDTH-1:0];
        end
      end
      carry_q <= chunk_sum[CHUNK_WIDTH];
      idx_q   <= last_chunk ? '0 : idx_q + IDX_W'(1);
      if (last_chunk) begin
        carry_out <= chunk_sum[CHUNK_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_chunked_add_serial.sv
// tb/tb_chunked_add_serial.sv - randomized self-checking bench for chunked_add_serial
// Exercises subtract mode too when CHUNKED_ADD_SERIAL_SUB_EN is defined.
module tb_chunked_add_serial;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        carry_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  chunked_add_serial dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef CHUNKED_ADD_SERIAL_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    longint unsigned s;
    s = longint'(x) + longint'(y);
    return {s >= 64'h1_0000_0000, s[31:0]};
  endfunction

  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return {x >= y, d};
  endfunction

  // Drives one op from IDLE (called #1 after an edge) and returns result, latency, timeout flag.
  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic sub_i,
                        output logic [31:0] o, output logic c, output int lat, output bit to);
    a = a_i; b = b_i; op_sub = sub_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
    o = out; c = carry_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, out, carry_out} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b out=%0d c=%b want rdy=1 vld=0 out=0 c=0",
               in_ready, out_valid, out, carry_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] av [3] = '{32'd1, 32'hFFFF_FFFF, 32'd1234500000};
    logic [31:0] bv [3] = '{32'd1, 32'd5, 32'd67890};
    logic [31:0] ov [3] = '{32'd2, 32'd4, 32'd1234567890};
    logic        cv [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] o; logic c; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 1'b0, o, c, lat, to);
      n_cmp++;
      if (to || o !== ov[i] || c !== cv[i] || lat != 4) begin
        n_fail++;
        $display("FAIL directed%0d: got out=%0d c=%b lat=%0d to=%0b want out=%0d c=%b lat=4",
                 i, o, c, lat, to, ov[i], cv[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    a = 32'd1234500000; b = 32'd67890; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    n = 0;
    while (!out_valid && n < 20) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_in_ready: got %b want 0 at busy cycle %0d", in_ready, n);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!out_valid || out !== 32'd1234567890 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: got vld=%b out=%0d c=%b want vld=1 out=1234567890 c=0",
               out_valid, out, carry_out);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    a = 32'd7; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 32'd10 || carry_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d: got vld=%b rdy=%b out=%0d c=%b want vld=1 rdy=0 out=10 c=0",
                 k, out_valid, in_ready, out, carry_out);
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'd10) begin
      n_fail++;
      $display("FAIL release: got vld=%b rdy=%b out=%0d want vld=0 rdy=1 out=10",
               out_valid, in_ready, out);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] o; logic c; int lat; bit to;
    a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got vld=%b rdy=%b out=%0h want vld=0 rdy=1 out=0",
               out_valid, in_ready, out);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd3, 32'd4, 1'b0, o, c, lat, to);
    n_cmp++;
    if (to || o !== 32'd7 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got out=%0d c=%b to=%0b want out=7 c=0", o, c, to);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, o; logic c; int lat; bit to; logic [32:0] exp;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = (i % 4 == 0) ? ~x + 32'($urandom_range(0, 2)) : $urandom;
      exp = ref_add(x, y);
      run_op(x, y, 1'b0, o, c, lat, to);
      n_cmp++;
      if (to || {c, o} !== exp || lat != 4) begin
        n_fail++;
        $display("FAIL random%0d: %h+%h got c=%b out=%h lat=%0d want c=%b out=%h lat=4",
                 i, x, y, c, o, lat, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y; logic [32:0] exp; int acc, prev, n;
    out_ready = 1'b1;
    x = $urandom; y = $urandom;
    a = x; b = y; op_sub = 1'b0; in_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      acc = cyc;
      exp = ref_add(x, y);
      if (i > 0) begin
        n_cmp++;
        if (acc - prev != 6) begin
          n_fail++;
          $display("FAIL b2b_period%0d: got %0d cycles want 6", i, acc - prev);
        end
      end
      prev = acc;
      x = $urandom; y = $urandom;
      a = x; b = y;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      n_cmp++;
      if (!out_valid || {carry_out, out} !== exp) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got vld=%b c=%b out=%h want c=%b out=%h",
                 i, out_valid, carry_out, out, exp[32], exp[31:0]);
      end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

`ifdef CHUNKED_ADD_SERIAL_SUB_EN
  task automatic test_sub();
    logic [31:0] av [3] = '{32'hFFFF_FFFF, 32'd1, 32'd3};
    logic [31:0] bv [3] = '{32'd5, 32'd1, 32'd7};
    logic [31:0] ov [3] = '{32'd4294967290, 32'd0, 32'd4294967292};
    logic        cv [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] x, y, o; logic c; int lat; bit to; logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 1'b1, o, c, lat, to);
      n_cmp++;
      if (to || o !== ov[i] || c !== cv[i]) begin
        n_fail++;
        $display("FAIL sub%0d: got out=%0d c=%b want out=%0d c=%b", i, o, c, ov[i], cv[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = (i % 5 == 0) ? x : $urandom;
      exp = ref_sub(x, y);
      run_op(x, y, 1'b1, o, c, lat, to);
      n_cmp++;
      if (to || {c, o} !== exp) begin
        n_fail++;
        $display("FAIL sub_random%0d: %h-%h got c=%b out=%h want c=%b out=%h",
                 i, x, y, c, o, exp[32], exp[31:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_back_to_back();
`ifdef CHUNKED_ADD_SERIAL_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
